tc_to_signmag_serial: RTL and testbench



---
 rtl/tc_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/tc_to_signmag_serial.sv | 122 ++++++++++++
 tb/tb_tc_to_signmag_serial.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared types for the serial two's-complement to sign-magnitude decoder.
package tc_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the serial arithmetic cell.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/tc_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder: one magnitude bit per
// clock, LSB first, through a single full adder and a carry flop.
module tc_to_signmag_serial
    import tc_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_minneg
);

    localparam logic [WIDTH-1:0] MIN_NEG_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_next;
    logic [CNT_W-1:0] cnt;
    logic             sign;
    logic             carry;
    logic             last_bit;
    logic             fa_a;
    logic             fa_sum;
    logic             fa_cout;

    // Negative operands become ~x + 1: invert each bit and seed the carry with 1.
    assign fa_a = src[0] ^ sign;

    full_adder u_fa (
        .A    (fa_a),
        .B    (1'b0),
        .Cin  (carry),
        .S    (fa_sum),
        .Cout (fa_cout)
    );

    assign result_next = {fa_sum, result[WIDTH-1:1]};
    assign last_bit    = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = CONV;
            end
            CONV: begin
                if (last_bit) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src   <= '0;
            sign  <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src   <= in_data;
                        sign  <= in_data[WIDTH-1];
                        carry <= in_data[WIDTH-1];
                        cnt   <= '0;
                    end
                end
                CONV: begin
                    src   <= src >> 1;
                    carry <= fa_cout;
                    cnt   <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs are loaded once on the final bit so they hold through the next
    // conversion, while the working result register keeps shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= '0;
            out_mag    <= '0;
            out_sign   <= 1'b0;
            out_minneg <= 1'b0;
        end else if (state == CONV) begin
            result <= result_next;
            if (last_bit) begin
                out_mag    <= result_next;
                out_sign   <= sign;
                out_minneg <= sign & (result_next == MIN_NEG_MAG);
            end
        end
    end

endmodule

// File: tb/tb_tc_to_signmag_serial.sv
// Self-checking bench for tc_to_signmag_serial: directed corner words plus
// random words, checked against an arithmetic sign/abs reference.
module tb_tc_to_signmag_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [W-1:0] out_mag;
    logic         out_minneg;

    int checks   = 0;
    int failures = 0;

    tc_to_signmag_serial #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_mag    (out_mag),
        .out_minneg (out_minneg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one word, optionally pokes in_valid during the conversion, then
    // applies `hold` cycles of backpressure before releasing the result.
    task automatic run_word(input logic [W-1:0] x, input int hold,
                            input int glitch_at, input logic [W-1:0] gdata);
        int           sv;
        int           edges;
        logic         e_sign;
        logic         e_min;
        logic [W-1:0] e_mag;

        sv     = int'($signed(x));
        e_sign = (sv < 0);
        e_mag  = W'(e_sign ? -sv : sv);
        e_min  = (sv == -(1 << (W - 1)));

        edges = 0;
        while (!in_ready && edges < 20) begin
            tick();
            edges++;
        end
        chk("in_ready_before_send", 32'(in_ready), 32'd1);

        in_valid = 1'b1;
        in_data  = x;
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        edges    = 1;  // the accepting edge counts as edge 1

        while (!out_valid && edges < 3 * W) begin
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            if (edges == glitch_at) begin
                in_valid = 1'b1;
                in_data  = gdata;
            end
            out_ready = 1'($urandom);
            tick();
            edges++;
            in_valid = 1'b0;
        end
        out_ready = 1'b0;

        chk("latency_edges", 32'(edges), 32'(W + 1));
        chk("out_sign", 32'(out_sign), 32'(e_sign));
        chk("out_mag", 32'(out_mag), 32'(e_mag));
        chk("out_minneg", 32'(out_minneg), 32'(e_min));
        chk("in_ready_done", 32'(in_ready), 32'd0);

        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_mag", 32'(out_mag), 32'(e_mag));
            chk("hold_sign", 32'(out_sign), 32'(e_sign));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_mag_kept", 32'(out_mag), 32'(e_mag));
        chk("release_sign_kept", 32'(out_sign), 32'(e_sign));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sign", 32'(out_sign), 32'd0);
        chk("rst_out_mag", 32'(out_mag), 32'd0);
        chk("rst_out_minneg", 32'(out_minneg), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_word(8'h05, 0, -1, 8'h00);
        run_word(8'hFB, 0, -1, 8'h00);
        run_word(8'hFF, 1, -1, 8'h00);
        run_word(8'h00, 0, -1, 8'h00);
        run_word(8'h80, 2, -1, 8'h00);
        run_word(8'h7F, 5, -1, 8'h00);
        run_word(8'h9C, 0, 3, 8'h33);

        // Mid-conversion reset must abort at once and discard the partial word.
        in_valid = 1'b1;
        in_data  = 8'hAB;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("pre_abort_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_mag", 32'(out_mag), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end
        run_word(8'hC8, 0, -1, 8'h00);

        for (int n = 0; n < 24; n++) begin
            run_word(W'($urandom), int'($urandom_range(0, 3)), -1, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
